// File: rtl/lcd_seq_pkg.sv
// Shared types and register map for the LCD SPI sequencer.
package lcd_seq_pkg;

  typedef struct packed {
    logic       kind;   // 0: SPI byte, 1: delay command
    logic       dc;
    logic [7:0] data;
  } entry_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_GAP,
    ST_DELAY
  } state_t;

  localparam logic [1:0] REG_TX     = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_CTRL   = 2'd2;
  localparam logic [1:0] REG_GAP    = 2'd3;

  localparam int ST_BUSY_BIT     = 0;
  localparam int ST_FULL_BIT     = 1;
  localparam int ST_EMPTY_BIT    = 2;
  localparam int ST_OVF_BIT      = 3;
  localparam int ST_COUNT_LSB    = 8;
  localparam int CTRL_ENABLE_BIT = 0;
  localparam int CTRL_FLUSH_BIT  = 1;

  function automatic entry_t unpack_tx(input logic [31:0] v);
    entry_t e;
    e.kind = v[9];
    e.dc   = v[8];
    e.data = v[7:0];
    return e;
  endfunction

endpackage

// File: rtl/lcd_spi_sequencer_fifo.sv
// Synchronous FIFO with flush; a push while full is dropped even if a pop occurs in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         data_i,
  input  logic                     pop_i,
  input  logic                     flush_i,
  output logic [WIDTH-1:0]         data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   DEPTH_C = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);
  localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == DEPTH_C);
  assign empty_o = (count_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign data_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries data only, so it is left out of reset.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/lcd_spi_sequencer.sv
// Bus-mapped command queue that drains bytes and delay commands into the LCD spi_controller.
module lcd_spi_sequencer
  import lcd_seq_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int DELAY_UNIT = 1000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] address_in,
  input  logic        sel_in,
  input  logic        read_in,
  output logic [31:0] read_value_out,
  input  logic [3:0]  write_mask_in,
  input  logic [31:0] write_value_in,
  output logic        ready_out,
  output logic        spi_start,
  output logic [7:0]  spi_data_out,
  output logic        spi_dc,
  input  logic        spi_busy,
  input  logic        spi_done
);

  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(255*DELAY_UNIT+1);
  localparam logic [CNT_W-1:0] UNIT    = CNT_W'(DELAY_UNIT);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [1:0]       reg_sel;
  logic             wr_en, push, flush, pop;
  logic             fifo_full, fifo_empty, busy;
  logic [AW:0]      fifo_count;
  logic [$bits(entry_t)-1:0] head_bits;
  entry_t           head;
  logic [31:0]      status;

  logic             enable_q, enable_d;
  logic [7:0]       gap_q, gap_d;
  logic             ovf_q, ovf_d;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             start_q, start_d;
  logic [7:0]       data_q, data_d;
  logic             dc_q, dc_d;

  logic unused_bus;
  assign unused_bus = ^{read_in, address_in[31:4], address_in[1:0],
                        write_mask_in[3:1], write_value_in[31:10]};

  assign reg_sel   = address_in[3:2];
  assign wr_en     = sel_in && write_mask_in[0];
  assign push      = wr_en && (reg_sel == REG_TX);
  assign flush     = wr_en && (reg_sel == REG_CTRL) && write_value_in[CTRL_FLUSH_BIT];
  assign ready_out = sel_in;
  assign head      = entry_t'(head_bits);
  assign busy      = (state_q != ST_IDLE) || !fifo_empty;

  sync_fifo #(
    .WIDTH ($bits(entry_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push_i  (push),
    .data_i  (unpack_tx(write_value_in)),
    .pop_i   (pop),
    .flush_i (flush),
    .data_o  (head_bits),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  always_comb begin
    enable_d = enable_q;
    gap_d    = gap_q;
    ovf_d    = ovf_q;
    if (wr_en) begin
      case (reg_sel)
        REG_TX:     if (fifo_full) ovf_d = 1'b1;
        REG_STATUS: if (write_value_in[ST_OVF_BIT]) ovf_d = 1'b0;
        REG_CTRL:   enable_d = write_value_in[CTRL_ENABLE_BIT];
        default:    gap_d = write_value_in[7:0];
      endcase
    end
  end

  always_comb begin
    status = '0;
    status[ST_BUSY_BIT]  = busy;
    status[ST_FULL_BIT]  = fifo_full;
    status[ST_EMPTY_BIT] = fifo_empty;
    status[ST_OVF_BIT]   = ovf_q;
    status[ST_COUNT_LSB +: AW+1] = fifo_count;
    read_value_out = '0;
    if (sel_in) begin
      case (reg_sel)
        REG_STATUS: read_value_out = status;
        REG_CTRL:   read_value_out = {31'b0, enable_q};
        REG_GAP:    read_value_out = {24'b0, gap_q};
        default:    read_value_out = '0;
      endcase
    end
  end

  // Start/data/dc are registered, so a pop in IDLE shows up on the bus one cycle later.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    start_d = 1'b0;
    data_d  = data_q;
    dc_d    = dc_q;
    pop     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (enable_q && !fifo_empty && !spi_busy) begin
          pop = 1'b1;
          if (!head.kind) begin
            data_d  = head.data;
            dc_d    = head.dc;
            start_d = 1'b1;
            state_d = ST_WAIT;
          end else begin
            cnt_d   = CNT_W'(head.data) * UNIT;
            state_d = ST_DELAY;
          end
        end
      end
      ST_WAIT: begin
        if (spi_done) begin
          if (gap_q != 8'd0) begin
            cnt_d   = CNT_W'(gap_q);
            state_d = ST_GAP;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: begin
        // A zero-length delay lands here with cnt==0 and leaves immediately.
        if (cnt_q <= CNT_ONE) state_d = ST_IDLE;
        else                  cnt_d   = cnt_q - CNT_ONE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      enable_q <= 1'b0;
      gap_q    <= '0;
      ovf_q    <= 1'b0;
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      start_q  <= 1'b0;
      data_q   <= '0;
      dc_q     <= 1'b0;
    end else begin
      enable_q <= enable_d;
      gap_q    <= gap_d;
      ovf_q    <= ovf_d;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      start_q  <= start_d;
      data_q   <= data_d;
      dc_q     <= dc_d;
    end
  end

  assign spi_start    = start_q;
  assign spi_data_out = data_q;
  assign spi_dc       = dc_q;

endmodule

// File: tb/tb_lcd_spi_sequencer.sv
// Directed bench for lcd_spi_sequencer: register table plus multi-cycle sequencing scenarios.
module tb_lcd_spi_sequencer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] address_in;
  logic        sel_in, read_in;
  logic [31:0] read_value_out;
  logic [3:0]  write_mask_in;
  logic [31:0] write_value_in;
  logic        ready_out;
  logic        spi_start;
  logic [7:0]  spi_data_out;
  logic        spi_dc;
  logic        spi_busy, spi_done;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int wcyc = 0;

  int         start_cyc[$];
  logic [7:0] start_data[$];
  logic       start_dc[$];
  int         done_cyc[$];

  localparam logic [1:0] R_TX = 2'd0, R_ST = 2'd1, R_CTRL = 2'd2, R_GAP = 2'd3;

  typedef struct {
    logic        wr;
    logic [3:0]  mask;
    logic [1:0]  wreg;
    logic [31:0] wv;
    logic [1:0]  rreg;
    logic [31:0] exp;
  } vec_t;
  vec_t vecs[10];

  lcd_spi_sequencer #(.FIFO_DEPTH(16), .DELAY_UNIT(10)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .address_in     (address_in),
    .sel_in         (sel_in),
    .read_in        (read_in),
    .read_value_out (read_value_out),
    .write_mask_in  (write_mask_in),
    .write_value_in (write_value_in),
    .ready_out      (ready_out),
    .spi_start      (spi_start),
    .spi_data_out   (spi_data_out),
    .spi_dc         (spi_dc),
    .spi_busy       (spi_busy),
    .spi_done       (spi_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Every high cycle of spi_start is logged, so a stretched pulse shows up as an extra entry.
  initial begin
    forever begin
      @(negedge clk);
      if (spi_start === 1'b1) begin
        start_cyc.push_back(cyc);
        start_data.push_back(spi_data_out);
        start_dc.push_back(spi_dc);
      end
    end
  end

  // spi_controller stand-in: done is seen by the DUT 8 cycles after the start cycle.
  initial begin
    spi_busy = 1'b0;
    spi_done = 1'b0;
    forever begin
      @(negedge clk);
      spi_done = 1'b0;
      if (spi_start === 1'b1 && !spi_busy) begin
        spi_busy = 1'b1;
        repeat (8) @(negedge clk);
        spi_busy = 1'b0;
        spi_done = 1'b1;
        done_cyc.push_back(cyc);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got time limit reached, required normal completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h required 0x%08h", name, act, exp);
    end
  endtask

  task automatic bus_write(input logic [1:0] r, input logic [31:0] v, input logic [3:0] m);
    @(negedge clk);
    sel_in = 1'b1; read_in = 1'b0; address_in = {28'h0, r, 2'b00};
    write_mask_in = m; write_value_in = v; wcyc = cyc;
    @(negedge clk);
    sel_in = 1'b0; write_mask_in = 4'h0; write_value_in = '0; address_in = '0;
  endtask

  task automatic bus_read(input logic [1:0] r, output logic [31:0] v);
    @(negedge clk);
    sel_in = 1'b1; read_in = 1'b1; write_mask_in = 4'h0; address_in = {28'h0, r, 2'b00};
    #1 v = read_value_out;
    @(negedge clk);
    sel_in = 1'b0; read_in = 1'b0; address_in = '0;
  endtask

  task automatic wait_starts(input int n, input int budget, input string name);
    int k;
    k = 0;
    while (start_cyc.size() < n && k < budget) begin
      @(negedge clk);
      #2;
      k++;
    end
    check(name, start_cyc.size(), n);
  endtask

  task automatic clear_logs();
    start_cyc.delete(); start_data.delete(); start_dc.delete(); done_cyc.delete();
  endtask

  logic [31:0] rv;
  logic        got;

  initial begin
    reset_n = 1'b0; sel_in = 1'b0; read_in = 1'b0; address_in = '0;
    write_mask_in = '0; write_value_in = '0;

    vecs[0] = '{1'b1, 4'hF, R_GAP,  32'h1A5, R_GAP,  32'h0000_00A5};
    vecs[1] = '{1'b1, 4'hF, R_CTRL, 32'h0,   R_CTRL, 32'h0};
    vecs[2] = '{1'b0, 4'h0, R_TX,   32'h0,   R_TX,   32'h0};
    vecs[3] = '{1'b1, 4'hF, R_TX,   32'h142, R_ST,   32'h0000_0101};
    vecs[4] = '{1'b1, 4'hF, R_TX,   32'h3FF, R_ST,   32'h0000_0201};
    vecs[5] = '{1'b1, 4'hF, R_ST,   32'h8,   R_ST,   32'h0000_0201};
    vecs[6] = '{1'b1, 4'hF, R_CTRL, 32'h2,   R_CTRL, 32'h0};
    vecs[7] = '{1'b0, 4'h0, R_TX,   32'h0,   R_ST,   32'h0000_0004};
    vecs[8] = '{1'b1, 4'hF, R_GAP,  32'h0,   R_GAP,  32'h0};
    vecs[9] = '{1'b1, 4'hE, R_GAP,  32'h33,  R_GAP,  32'h0};

    repeat (3) @(negedge clk);
    check("rst_start", spi_start, 0);
    check("rst_data", spi_data_out, 0);
    check("rst_dc", spi_dc, 0);
    reset_n = 1'b1;
    @(negedge clk);
    #1;
    check("idle_rdata", read_value_out, 0);
    check("idle_ready", ready_out, 0);
    bus_read(R_ST, rv);   check("rst_status", rv, 32'h4);
    bus_read(R_CTRL, rv); check("rst_ctrl", rv, 0);
    bus_read(R_GAP, rv);  check("rst_gap", rv, 0);

    for (int i = 0; i < 10; i++) begin
      if (vecs[i].wr) bus_write(vecs[i].wreg, vecs[i].wv, vecs[i].mask);
      bus_read(vecs[i].rreg, rv);
      check($sformatf("vec%0d", i), rv, vecs[i].exp);
    end

    // Two back-to-back bytes with no gap.
    clear_logs();
    bus_write(R_TX, 32'h02A, 4'hF);
    bus_write(R_TX, 32'h100, 4'hF);
    bus_write(R_CTRL, 32'h1, 4'hF);
    wait_starts(2, 100, "t1_starts");
    repeat (20) @(negedge clk);
    check("t1_pulses", start_cyc.size(), 2);
    check("t1_data0", {start_dc[0], start_data[0]}, 32'h02A);
    check("t1_data1", {start_dc[1], start_data[1]}, 32'h100);
    check("t1_latency", start_cyc[1] - done_cyc[0], 2);
    bus_write(R_CTRL, 32'h0, 4'hF);

    // Inter-byte gap of 5.
    clear_logs();
    bus_write(R_GAP, 32'h5, 4'hF);
    bus_write(R_TX, 32'h0A1, 4'hF);
    bus_write(R_TX, 32'h1A2, 4'hF);
    bus_write(R_TX, 32'h0A3, 4'hF);
    bus_write(R_CTRL, 32'h1, 4'hF);
    wait_starts(3, 200, "t2_starts");
    repeat (20) @(negedge clk);
    check("t2_pulses", start_cyc.size(), 3);
    check("t2_gap01", start_cyc[1] - done_cyc[0], 7);
    check("t2_gap12", start_cyc[2] - done_cyc[1], 7);
    check("t2_data2", {start_dc[2], start_data[2]}, 32'h0A3);
    bus_write(R_CTRL, 32'h0, 4'hF);
    bus_write(R_GAP, 32'h0, 4'hF);

    // Delay entry of 3 units (30 cycles): enable lands W+1 (pop), DELAY W+2..W+31, IDLE W+32, start W+33.
    clear_logs();
    bus_write(R_TX, 32'h203, 4'hF);
    bus_write(R_TX, 32'h011, 4'hF);
    bus_write(R_CTRL, 32'h1, 4'hF);
    wait_starts(1, 100, "t3_starts");
    check("t3_delay", start_cyc[0] - wcyc, 33);
    check("t3_data", {start_dc[0], start_data[0]}, 32'h011);
    repeat (20) @(negedge clk);
    bus_write(R_CTRL, 32'h0, 4'hF);

    // Zero-length delay costs one DELAY cycle only.
    clear_logs();
    bus_write(R_TX, 32'h200, 4'hF);
    bus_write(R_TX, 32'h055, 4'hF);
    bus_write(R_CTRL, 32'h1, 4'hF);
    wait_starts(1, 50, "t3z_starts");
    check("t3z_delay", start_cyc[0] - wcyc, 4);
    repeat (20) @(negedge clk);
    bus_write(R_CTRL, 32'h0, 4'hF);

    // Overflow with enable off.
    clear_logs();
    for (int i = 0; i < 17; i++) bus_write(R_TX, 32'h040 + i, 4'hF);
    bus_read(R_ST, rv);   check("t4_full", rv, 32'h0000_100B);
    bus_write(R_ST, 32'h8, 4'hF);
    bus_read(R_ST, rv);   check("t4_clr", rv, 32'h0000_1003);
    bus_write(R_CTRL, 32'h2, 4'hF);
    bus_read(R_ST, rv);   check("t4_flush", rv, 32'h4);
    check("t4_nostart", start_cyc.size(), 0);

    // Flush while the first byte is in flight.
    clear_logs();
    for (int i = 0; i < 7; i++) bus_write(R_TX, 32'h010 + i, 4'hF);
    bus_write(R_CTRL, 32'h1, 4'hF);
    wait_starts(1, 50, "t5_first");
    bus_write(R_CTRL, 32'h3, 4'hF);
    repeat (20) @(negedge clk);
    check("t5_pulses", start_cyc.size(), 1);
    check("t5_data", {start_dc[0], start_data[0]}, 32'h010);
    check("t5_done", done_cyc.size(), 1);
    bus_read(R_ST, rv);   check("t5_status", rv, 32'h4);
    bus_write(R_CTRL, 32'h0, 4'hF);

    // Asynchronous reset in the start cycle.
    clear_logs();
    bus_write(R_TX, 32'h1C3, 4'hF);
    bus_write(R_TX, 32'h0C4, 4'hF);
    bus_write(R_CTRL, 32'h1, 4'hF);
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (spi_start === 1'b1) got = 1'b1;
    end
    check("t6_seen", got, 1);
    check("t6_pre_data", {spi_dc, spi_data_out}, 32'h1C3);
    reset_n = 1'b0;
    #1;
    check("t6_start", spi_start, 0);
    check("t6_data", {spi_dc, spi_data_out}, 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (15) @(negedge clk);
    bus_read(R_ST, rv);   check("t6_status", rv, 32'h4);
    bus_read(R_CTRL, rv); check("t6_ctrl", rv, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
